// File: rtl/mips_mc_control_p.sv
// mips_mc_control_p: multicycle MIPS control FSM driving datapath enables and mux selects
module mips_mc_control_p #(
  parameter logic [3:0] MEM_WAIT = 4'd1,
  parameter bit HALT_ON_BREAK = 1'b1,
  parameter bit EXC_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  output logic       pc_write,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       mdr_write,
  output logic       epc_write,
  output logic [2:0] alu_op,
  output logic [1:0] mux_iord,
  output logic [1:0] mux_alu_src_a,
  output logic [1:0] mux_alu_src_b,
  output logic [2:0] mux_reg_dst,
  output logic [2:0] mux_mem_to_reg,
  output logic [2:0] mux_pc_source,
  output logic       rst_out,
  output logic       halted
);
  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_FWAIT, S_IR, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB,
    S_BRANCH, S_JUMP, S_JAL, S_JR, S_RTE, S_ADDR, S_LOAD, S_LWAIT, S_LMDR,
    S_LWB, S_STORE, S_EXC_EPC, S_EXC_VEC, S_BRK, S_HALT
  } state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic cause_ovf;
  logic r_type, r_alu, i_alu, ovf_op, is_slt;
  logic [2:0] exec_alu;
  assign r_type = opcode == 6'h00;
  assign r_alu = r_type && funct inside {6'h20, 6'h22, 6'h24, 6'h2A};
  assign i_alu = opcode inside {6'h08, 6'h09, 6'h0A};
  assign ovf_op = (r_type && funct inside {6'h20, 6'h22}) || opcode == 6'h08;
  assign is_slt = r_type ? funct == 6'h2A : opcode == 6'h0A;
  assign exec_alu = r_type ? (funct == 6'h22 ? 3'b010 : funct == 6'h24 ? 3'b011 :
                              funct == 6'h2A ? 3'b111 : 3'b001)
                           : (opcode == 6'h0A ? 3'b111 : 3'b001);
  // The wait counter reloads every non-wait cycle, so it holds MEM_WAIT-1 on entry to a wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
      cnt <= '0;
      cause_ovf <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == S_FWAIT || state == S_LWAIT) ? cnt - 4'd1 : MEM_WAIT - 4'd1;
      if (nxt == S_EXC_EPC) cause_ovf <= state == S_EXEC_R || state == S_EXEC_I;
    end
  end
  always_comb begin
    nxt = state;
    pc_write = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    ab_write = 1'b0;
    aluout_write = 1'b0;
    mdr_write = 1'b0;
    epc_write = 1'b0;
    alu_op = 3'b000;
    mux_iord = 2'b00;
    mux_alu_src_a = 2'b00;
    mux_alu_src_b = 2'b00;
    mux_reg_dst = 3'b000;
    mux_mem_to_reg = 3'b000;
    mux_pc_source = 3'b000;
    rst_out = 1'b0;
    halted = 1'b0;
    case (state)
      S_RESET: begin
        reg_write = 1'b1;
        mux_reg_dst = 3'b100;
        rst_out = 1'b1;
        nxt = S_FETCH;
      end
      S_FETCH: nxt = MEM_WAIT != 4'd0 ? S_FWAIT : S_IR;
      S_FWAIT: nxt = cnt == 4'd0 ? S_IR : S_FWAIT;
      S_IR: begin
        ir_write = 1'b1;
        mux_alu_src_b = 2'b01;
        alu_op = 3'b001;
        mux_pc_source = 3'b001;
        pc_write = 1'b1;
        nxt = S_DECODE;
      end
      S_DECODE: begin
        ab_write = 1'b1;
        mux_alu_src_b = 2'b11;
        alu_op = 3'b001;
        aluout_write = 1'b1;
        nxt = r_alu ? S_EXEC_R : i_alu ? S_EXEC_I :
              opcode inside {6'h04, 6'h05} ? S_BRANCH :
              opcode == 6'h02 ? S_JUMP : opcode == 6'h03 ? S_JAL :
              opcode inside {6'h23, 6'h2B} ? S_ADDR :
              (r_type && funct == 6'h08) ? S_JR :
              (r_type && funct == 6'h13) ? S_RTE :
              (r_type && funct == 6'h0D) ? S_BRK :
              EXC_EN ? S_EXC_EPC : S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        mux_alu_src_a = 2'b10;
        mux_alu_src_b = state == S_EXEC_I ? 2'b10 : 2'b00;
        alu_op = exec_alu;
        aluout_write = 1'b1;
        nxt = (EXC_EN && overflow && ovf_op) ? S_EXC_EPC : S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        mux_mem_to_reg = is_slt ? 3'b101 : 3'b110;
        mux_reg_dst = r_type ? 3'b010 : 3'b000;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        mux_alu_src_a = 2'b10;
        alu_op = 3'b010;
        mux_pc_source = 3'b010;
        pc_write = opcode[0] ? !zero : zero;
        nxt = S_FETCH;
      end
      S_JUMP, S_JAL: begin
        mux_pc_source = 3'b110;
        pc_write = 1'b1;
        reg_write = state == S_JAL;
        mux_reg_dst = state == S_JAL ? 3'b011 : 3'b000;
        mux_mem_to_reg = state == S_JAL ? 3'b111 : 3'b000;
        nxt = S_FETCH;
      end
      S_JR: begin
        mux_alu_src_a = 2'b10;
        mux_pc_source = 3'b001;
        pc_write = 1'b1;
        nxt = S_FETCH;
      end
      S_RTE: begin
        mux_pc_source = 3'b011;
        pc_write = 1'b1;
        nxt = S_FETCH;
      end
      S_ADDR: begin
        mux_alu_src_a = 2'b10;
        mux_alu_src_b = 2'b10;
        alu_op = 3'b001;
        aluout_write = 1'b1;
        nxt = opcode == 6'h23 ? S_LOAD : S_STORE;
      end
      S_LOAD: begin
        mux_iord = 2'b01;
        nxt = MEM_WAIT != 4'd0 ? S_LWAIT : S_LMDR;
      end
      S_LWAIT: nxt = cnt == 4'd0 ? S_LMDR : S_LWAIT;
      S_LMDR: begin
        mdr_write = 1'b1;
        nxt = S_LWB;
      end
      S_LWB: begin
        reg_write = 1'b1;
        mux_mem_to_reg = 3'b001;
        nxt = S_FETCH;
      end
      S_STORE: begin
        mux_iord = 2'b01;
        mem_write = 1'b1;
        nxt = S_FETCH;
      end
      S_EXC_EPC: begin
        mux_alu_src_b = 2'b01;
        alu_op = 3'b010;
        epc_write = 1'b1;
        nxt = S_EXC_VEC;
      end
      S_EXC_VEC: begin
        pc_write = 1'b1;
        mux_pc_source = cause_ovf ? 3'b100 : 3'b101;
        nxt = S_FETCH;
      end
      S_BRK: begin
        if (HALT_ON_BREAK) nxt = S_HALT;
        else begin
          mux_alu_src_b = 2'b01;
          alu_op = 3'b010;
          mux_pc_source = 3'b001;
          pc_write = 1'b1;
          nxt = S_FETCH;
        end
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_control_p.sv
// tb_mips_mc_control_p: scoreboard bench over three parameter sets of the multicycle control FSM
module tb_mips_mc_control_p;
  typedef struct packed {
    logic pcw, mw, irw, rw, abw, aow, mdrw, epcw;
    logic [2:0] alu;
    logic [1:0] iord, sa, sb;
    logic [2:0] rd, m2r, pcs;
    logic ro, hl;
  } ov_t;
  localparam logic [11:0] MWS = {4'd0, 4'd2, 4'd1};
  localparam logic [2:0] HOB = 3'b011;
  localparam logic [2:0] EXE = 3'b011;
  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic overflow = 1'b0, zero = 1'b0;
  int sel = 0, total = 0, bad = 0;
  string cur = "idle";
  ov_t q[$];
  ov_t obs, e_mon;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : d
    logic pc_write, mem_write, ir_write, reg_write, ab_write, aluout_write, mdr_write, epc_write;
    logic [2:0] alu_op, mux_reg_dst, mux_mem_to_reg, mux_pc_source;
    logic [1:0] mux_iord, mux_alu_src_a, mux_alu_src_b;
    logic rst_out, halted;
    ov_t ov;
    mips_mc_control_p #(.MEM_WAIT(MWS[g*4 +: 4]), .HALT_ON_BREAK(HOB[g]), .EXC_EN(EXE[g])) u (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .overflow(overflow), .zero(zero),
      .pc_write(pc_write), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .ab_write(ab_write), .aluout_write(aluout_write), .mdr_write(mdr_write), .epc_write(epc_write),
      .alu_op(alu_op), .mux_iord(mux_iord), .mux_alu_src_a(mux_alu_src_a),
      .mux_alu_src_b(mux_alu_src_b), .mux_reg_dst(mux_reg_dst), .mux_mem_to_reg(mux_mem_to_reg),
      .mux_pc_source(mux_pc_source), .rst_out(rst_out), .halted(halted));
    assign ov = {pc_write, mem_write, ir_write, reg_write, ab_write, aluout_write, mdr_write,
                 epc_write, alu_op, mux_iord, mux_alu_src_a, mux_alu_src_b, mux_reg_dst,
                 mux_mem_to_reg, mux_pc_source, rst_out, halted};
  end
  assign obs = sel == 0 ? d[0].ov : sel == 1 ? d[1].ov : d[2].ov;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input ov_t e);
    q.push_back(e);
  endtask
  always @(negedge clk) if (q.size() > 0) begin
    e_mon = q.pop_front();
    check(cur, 32'(obs), 32'(e_mon));
  end
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({cur, "_drain"}, 32'(q.size()), 0);
    q.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 32'(obs.ro), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cur = "reset";
    put('{rw: 1'b1, rd: 3'b100, ro: 1'b1, default: '0});
    drain();
  endtask
  task automatic trap(input logic ovf);
    put('{sb: 2'b01, alu: 3'b010, epcw: 1'b1, default: '0});
    put('{pcw: 1'b1, pcs: ovf ? 3'b100 : 3'b101, default: '0});
  endtask
  task automatic issue(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, input logic zf);
    int mw;
    logic h, ex, rt, slt;
    logic [2:0] alu;
    mw = int'(MWS[sel*4 +: 4]);
    h = HOB[sel];
    ex = EXE[sel];
    rt = op == 6'h00;
    slt = rt ? fn == 6'h2A : op == 6'h0A;
    alu = rt ? (fn == 6'h22 ? 3'd2 : fn == 6'h24 ? 3'd3 : fn == 6'h2A ? 3'd7 : 3'd1)
             : (op == 6'h0A ? 3'd7 : 3'd1);
    @(posedge clk);
    #1;
    cur = tag;
    opcode = op;
    funct = fn;
    overflow = ovf;
    zero = zf;
    put('0);
    repeat (mw) put('0);
    put('{pcw: 1'b1, irw: 1'b1, sb: 2'b01, alu: 3'b001, pcs: 3'b001, default: '0});
    put('{abw: 1'b1, aow: 1'b1, sb: 2'b11, alu: 3'b001, default: '0});
    if ((rt && fn inside {6'h20, 6'h22, 6'h24, 6'h2A}) || op inside {6'h08, 6'h09, 6'h0A}) begin
      put('{sa: 2'b10, sb: rt ? 2'b00 : 2'b10, alu: alu, aow: 1'b1, default: '0});
      if (ex && ovf && (rt ? fn inside {6'h20, 6'h22} : op == 6'h08)) trap(1'b1);
      else put('{rw: 1'b1, rd: rt ? 3'b010 : 3'b000, m2r: slt ? 3'b101 : 3'b110, default: '0});
    end else if (op inside {6'h04, 6'h05})
      put('{sa: 2'b10, alu: 3'b010, pcs: 3'b010, pcw: op == 6'h04 ? zf : !zf, default: '0});
    else if (op == 6'h02) put('{pcs: 3'b110, pcw: 1'b1, default: '0});
    else if (op == 6'h03)
      put('{pcs: 3'b110, pcw: 1'b1, rw: 1'b1, rd: 3'b011, m2r: 3'b111, default: '0});
    else if (op inside {6'h23, 6'h2B}) begin
      put('{sa: 2'b10, sb: 2'b10, alu: 3'b001, aow: 1'b1, default: '0});
      if (op == 6'h2B) put('{iord: 2'b01, mw: 1'b1, default: '0});
      else begin
        put('{iord: 2'b01, default: '0});
        repeat (mw) put('0);
        put('{mdrw: 1'b1, default: '0});
        put('{rw: 1'b1, m2r: 3'b001, default: '0});
      end
    end else if (rt && fn == 6'h08) put('{sa: 2'b10, pcs: 3'b001, pcw: 1'b1, default: '0});
    else if (rt && fn == 6'h13) put('{pcs: 3'b011, pcw: 1'b1, default: '0});
    else if (rt && fn == 6'h0D) begin
      if (h) begin
        put('0);
        repeat (20) put('{hl: 1'b1, default: '0});
      end else put('{sb: 2'b01, alu: 3'b010, pcs: 3'b001, pcw: 1'b1, default: '0});
    end else if (ex) trap(1'b0);
    drain();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    sel = 0;
    do_reset();
    issue("add_mw1", 6'h00, 6'h20, 1'b0, 1'b0);
    issue("beq_nz", 6'h04, 6'h00, 1'b0, 1'b0);
    issue("bne_nz", 6'h05, 6'h00, 1'b0, 1'b0);
    issue("op3f_trap", 6'h3F, 6'h00, 1'b0, 1'b0);
    issue("break_halt", 6'h00, 6'h0D, 1'b0, 1'b0);
    sel = 1;
    do_reset();
    issue("add_mw2", 6'h00, 6'h20, 1'b0, 1'b0);
    issue("addi_ovf", 6'h08, 6'h00, 1'b1, 1'b0);
    issue("sub_ovf", 6'h00, 6'h22, 1'b1, 1'b0);
    issue("addiu_ovf", 6'h09, 6'h00, 1'b1, 1'b0);
    issue("and", 6'h00, 6'h24, 1'b0, 1'b0);
    issue("slt", 6'h00, 6'h2A, 1'b0, 1'b0);
    issue("slti", 6'h0A, 6'h00, 1'b0, 1'b0);
    issue("beq_z", 6'h04, 6'h00, 1'b0, 1'b1);
    issue("bne_z", 6'h05, 6'h00, 1'b0, 1'b1);
    issue("j", 6'h02, 6'h00, 1'b0, 1'b0);
    issue("jal", 6'h03, 6'h00, 1'b0, 1'b0);
    issue("jr", 6'h00, 6'h08, 1'b0, 1'b0);
    issue("rte", 6'h00, 6'h13, 1'b0, 1'b0);
    issue("lw_mw2", 6'h23, 6'h00, 1'b0, 1'b0);
    issue("sw_mw2", 6'h2B, 6'h00, 1'b0, 1'b0);
    issue("bad_funct", 6'h00, 6'h3F, 1'b0, 1'b0);
    sel = 2;
    do_reset();
    issue("lw_mw0", 6'h23, 6'h00, 1'b0, 1'b0);
    issue("sw_mw0", 6'h2B, 6'h00, 1'b0, 1'b0);
    issue("add_ovf_noexc", 6'h00, 6'h20, 1'b1, 1'b0);
    issue("op3f_nop", 6'h3F, 6'h00, 1'b0, 1'b0);
    issue("break_refetch", 6'h00, 6'h0D, 1'b0, 1'b0);
    issue("addi_mw0", 6'h08, 6'h00, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
